mem_arbiter: RTL and testbench

Two-requester arbiter for the single-port 16-bit word memory. It shares the memory between the control unit (requester 0: instruction fetch and load/store) and a secondary master (requester 1: program loader / debug port). Requester 0 has priority. A wait counter guarantees requester 1 a slot after a bounded stall. The block drives the memory port directly and returns read data to whichever requester issued the read.

---
 rtl/mem_arbiter.sv | 69 ++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port synchronous-read memory; r0 has priority,
// r1 is forced in after WAIT_MAX refused cycles. Grant is same-cycle, read data returns one cycle later.
module mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int WAIT_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_out
);
    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] WMAX = CW'(WAIT_MAX);

    logic [CW-1:0] wait_cnt;
    logic          rd_pend;
    logic          rd_owner;
    logic          r1_due;
    logic          rd_acc;

    // r1 overrides r0 only once it has been refused WAIT_MAX cycles in a row
    assign r1_due = r1_req && (wait_cnt >= WMAX);
    assign r1_gnt = rst_n && r1_req && (r1_due || !r0_req);
    assign r0_gnt = rst_n && r0_req && !r1_due;

    assign mem_addr = r1_gnt ? r1_addr  : r0_addr;
    assign mem_in   = r1_gnt ? r1_wdata : r0_wdata;
    assign mem_we   = (r0_gnt && r0_we) || (r1_gnt && r1_we);
    assign rd_acc   = (r0_gnt && !r0_we) || (r1_gnt && !r1_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            if (r1_req && !r1_gnt)
                wait_cnt <= (wait_cnt == WMAX) ? WMAX : wait_cnt + CW'(1);
            else
                wait_cnt <= '0;
            rd_pend <= rd_acc;
            if (rd_acc)
                rd_owner <= r1_gnt;
        end
    end

    // mem_out is broadcast; rvalid alone tells each requester whether it is theirs
    assign r0_rvalid = rd_pend && !rd_owner;
    assign r1_rvalid = rd_pend && rd_owner;
    assign r0_rdata  = mem_out;
    assign r1_rdata  = mem_out;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int WAIT_MAX = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [7:0]  r0_addr, r1_addr;
    logic [15:0] r0_wdata, r1_wdata;
    logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [15:0] r0_rdata, r1_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_in, mem_out;
    logic        mem_we;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(16), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_in(mem_in), .mem_we(mem_we), .mem_out(mem_out)
    );

    function automatic logic [15:0] init_word(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    // Synchronous-read memory; reloads its initial image while reset is held
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(8'(i));
            mem_out <= 16'h0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_in;
            mem_out <= mem[mem_addr];
        end
    end

    // Reference model: shadow memory, refusal count, and the one read expected back next cycle
    logic [15:0] shadow [256];
    int          refused;
    logic        pend_vld, pend_own;
    logic [15:0] pend_dat;
    logic        last_g0, last_g1;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) shadow[i] = init_word(8'(i));
        refused  = 0;
        pend_vld = 1'b0;
        pend_own = 1'b0;
        pend_dat = 16'h0;
        last_g0  = 1'b0;
        last_g1  = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: check all outputs against the model, advance it, move to posedge+1
    task automatic model_cycle();
        logic        eg0, eg1, ewr, erd;
        logic [7:0]  ea;
        logic [15:0] ed;
        eg1 = r1_req && (refused >= WAIT_MAX || !r0_req);
        eg0 = r0_req && !eg1;
        ea  = eg1 ? r1_addr : r0_addr;
        ed  = eg1 ? r1_wdata : r0_wdata;
        ewr = (eg0 && r0_we) || (eg1 && r1_we);
        erd = (eg0 && !r0_we) || (eg1 && !r1_we);
        chk("r0_gnt", 32'(r0_gnt), 32'(eg0));
        chk("r1_gnt", 32'(r1_gnt), 32'(eg1));
        chk("mem_we", 32'(mem_we), 32'(ewr));
        if (eg0 || eg1) chk("mem_addr", 32'(mem_addr), 32'(ea));
        if (ewr) chk("mem_in", 32'(mem_in), 32'(ed));
        chk("r0_rvalid", 32'(r0_rvalid), 32'(pend_vld && !pend_own));
        chk("r1_rvalid", 32'(r1_rvalid), 32'(pend_vld && pend_own));
        if (pend_vld && !pend_own) chk("r0_rdata", 32'(r0_rdata), 32'(pend_dat));
        if (pend_vld && pend_own)  chk("r1_rdata", 32'(r1_rdata), 32'(pend_dat));
        pend_vld = erd;
        pend_own = eg1;
        pend_dat = shadow[ea];
        if (ewr) shadow[ea] = ed;
        refused = (r1_req && !eg1) ? refused + 1 : 0;
        last_g0 = eg0;
        last_g1 = eg1;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic drive(input logic q0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                         input logic q1, input logic w1, input logic [7:0] a1, input logic [15:0] d1);
        r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
    endtask

    typedef struct {
        logic        q0, w0;
        logic [7:0]  a0;
        logic [15:0] d0;
        logic        q1, w1;
        logic [7:0]  a1;
        logic [15:0] d1;
        logic [1:0]  gnt;   // {r1,r0}
        logic [1:0]  rv;    // {r1,r0}
        logic [15:0] rd;
    } vec_t;

    vec_t vecs [20];

    task automatic fill_vecs();
        vecs[0]  = '{1'b1, 1'b0, 8'h10, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0,    2'b01, 2'b00, 16'h0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0,    2'b00, 2'b01, 16'hBEEF};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b1, 8'h20, 16'h1234, 2'b10, 2'b00, 16'h0};
        vecs[3]  = '{1'b1, 1'b0, 8'h20, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0,    2'b01, 2'b00, 16'h0};
        vecs[4]  = '{1'b1, 1'b0, 8'h02, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0,    2'b01, 2'b01, 16'h1234};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h04, 16'h0,    2'b10, 2'b01, 16'h02FD};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0,    2'b00, 2'b10, 16'h04FB};
        for (int i = 7; i <= 14; i++) begin
            vecs[i] = '{1'b1, 1'b0, 8'h02, 16'h0, 1'b1, 1'b0, 8'h04, 16'h0, 2'b01, 2'b01, 16'h02FD};
        end
        vecs[7].rv  = 2'b00;
        vecs[10].gnt = 2'b10;
        vecs[11].rv = 2'b10; vecs[11].rd = 16'h04FB;
        vecs[14].gnt = 2'b10;
        vecs[15] = '{1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0,    2'b00, 2'b10, 16'h04FB};
        // r1 drops its request before being served: its refusal run must restart
        vecs[16] = '{1'b1, 1'b0, 8'h02, 16'h0, 1'b1, 1'b0, 8'h04, 16'h0,    2'b01, 2'b00, 16'h0};
        vecs[17] = '{1'b1, 1'b0, 8'h02, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0,    2'b01, 2'b01, 16'h02FD};
        vecs[18] = '{1'b1, 1'b0, 8'h02, 16'h0, 1'b1, 1'b0, 8'h04, 16'h0,    2'b01, 2'b01, 16'h02FD};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0,    2'b00, 2'b01, 16'h02FD};
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 8'h10, 16'h0, 1'b1, 1'b0, 8'h04, 16'h0);
        model_reset();
        fill_vecs();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_r0_gnt", 32'(r0_gnt), 32'd0);
        chk("rst_r1_gnt", 32'(r1_gnt), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        chk("rst_r1_rvalid", 32'(r1_rvalid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_r0_first", 32'(r0_gnt), 32'd1);
        model_cycle();
        drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        step();

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].q0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                  vecs[i].q1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), 32'({r1_gnt, r0_gnt}), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_rv", i), 32'({r1_rvalid, r0_rvalid}), 32'(vecs[i].rv));
            if (vecs[i].rv[0]) chk($sformatf("vec%0d_r0_rdata", i), 32'(r0_rdata), 32'(vecs[i].rd));
            if (vecs[i].rv[1]) chk($sformatf("vec%0d_r1_rdata", i), 32'(r1_rdata), 32'(vecs[i].rd));
            model_cycle();
        end

        // Random traffic; a refused requester keeps its request stable until granted
        for (int n = 0; n < 400; n++) begin
            if (!(r0_req && !last_g0)) begin
                r0_req   = ($urandom_range(0, 9) < 7);
                r0_we    = ($urandom_range(0, 9) < 3);
                r0_addr  = 8'($urandom_range(0, 15));
                r0_wdata = 16'($urandom);
            end
            if (!(r1_req && !last_g1)) begin
                r1_req   = ($urandom_range(0, 9) < 6);
                r1_we    = ($urandom_range(0, 9) < 3);
                r1_addr  = 8'($urandom_range(0, 15));
                r1_wdata = 16'($urandom);
            end
            step();
        end

        // Reset lands between acceptance of an r0 read and its return edge
        drive(1'b1, 1'b0, 8'h10, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        @(negedge clk);
        chk("midrd_accept", 32'(r0_gnt), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrd_gnt_forced", 32'(r0_gnt), 32'd0);
        chk("midrd_we_forced", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        chk("midrd_no_rvalid_a", 32'(r0_rvalid), 32'd0);
        @(negedge clk);
        chk("midrd_no_rvalid_b", 32'(r0_rvalid), 32'd0);
        chk("midrd_no_r1_rvalid", 32'(r1_rvalid), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // Fresh wait counter: r0 must get exactly WAIT_MAX grants before r1 is forced in
        drive(1'b1, 1'b0, 8'h10, 16'h0, 1'b1, 1'b0, 8'h04, 16'h0);
        for (int i = 0; i < 8; i++) step();
        drive(1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
